trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Multi-cycle trap sequencer for the pipelined RV32I core with exception/interrupt support. Sits beside the EX stage and takes its inputs from there:
- decoder exception flags (illegal instruction, ecall, mret)
- external and timer interrupt lines
- CSR file state

On a trap it flushes the pipeline and sequences the mepc/mcause/mstatus writes over a dedicated CSR write port. It then redirects fetch to mtvec. On mret it restores mstatus and redirects fetch to mepc.

Parameters:
XLEN, 32, datapath/CSR width
IRQ_SYNC_STAGES, 2, flop stages on irq_ext synchronizer (min 2)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  valid instruction occupies EX
ex_pc  in  XLEN  PC of EX instruction
ex_invalid  in  1  decoder invalid_instruction for EX instruction
ex_ecall  in  1  EX instruction is ecall
ex_mret  in  1  EX instruction is mret
irq_ext  in  1  external interrupt, asynchronous, level
irq_timer  in  1  timer interrupt, synchronous to clk, level
mstatus  in  XLEN  current mstatus
mie  in  XLEN  current mie (bit 11 MEIE, bit 7 MTIE)
mtvec  in  XLEN  current mtvec
mepc  in  XLEN  current mepc
csr_trap_we  out  1  CSR write strobe (priority over instruction CSR writes)
csr_trap_addr  out  12  CSR address
csr_trap_wdata  out  XLEN  CSR write data
flush  out  1  kill IF/ID/EX contents
stall  out  1  freeze PC and IF/ID
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  XLEN  fetch target
busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
  - rst_n=0 forces state IDLE, clears latches and synchronizer.
  - All outputs go to 0 immediately, including mid-sequence.
- FSM states: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, REDIRECT.
- Outputs are Moore-decoded from the state register. In IDLE all outputs are 0.
- irq_ext passes through an IRQ_SYNC_STAGES-flop synchronizer before use (irq_s).
- Trap detection is evaluated only in IDLE with ex_valid=1, with this priority:
  1. ex_invalid → cause 2
  2. ex_ecall → cause 11
  3. mstatus[3] & mie[11] & irq_s → cause 0x8000000B
  4. mstatus[3] & mie[7] & irq_timer → cause 0x80000007
  5. ex_mret → mret sequence
- On a detect at cycle T, the block latches pc_q=ex_pc, cause_q, mstatus_q=mstatus, mtvec_q=mtvec and mepc_q=mepc.
  - Trap: next state T_MEPC.
  - mret: next state R_MSTATUS.
- Trap sequence (one state per cycle):
  - T+1 T_MEPC: write 0x341 ← {pc_q[31:2],2'b00}.
  - T+2 T_MCAUSE: write 0x342 ← cause_q.
  - T+3 T_MSTATUS: write 0x300 ← mstatus_q with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
  - T+4 REDIRECT: redirect_pc={mtvec_q[31:2],2'b00}.
  - T+5 IDLE.
- mret sequence:
  - T+1 R_MSTATUS: write 0x300 ← mstatus_q with MIE=MPIE, MPIE=1, MPP=2'b11.
  - T+2 REDIRECT: redirect_pc={mepc_q[31:2],2'b00}.
  - T+3 IDLE.
- flush, stall and busy are 1 in every non-IDLE state. redirect_valid is 1 only in REDIRECT.
- The interrupted or excepting instruction is not committed; mepc = its PC, so an interrupted instruction re-executes after mret.
- While busy, all inputs are ignored. Interrupts pending at the end of a sequence are taken on the next IDLE evaluation. After mret, MIE is restored from the latched value, not the pre-write mstatus input.
- No detection when ex_valid=0 (bubble); pending interrupts wait for a valid instruction.
- Widths: cause and wdata are XLEN; addresses are fixed 12-bit constants. No arithmetic overflow paths except the vectored add below, which wraps modulo 2^XLEN.

Optional Feature:
Macro TRAP_VECTORED_EN.
- Defined: when mtvec_q[1:0]==2'b01 and the trap is an interrupt, redirect_pc = {mtvec_q[31:2],2'b00} + 4*cause_q[30:0]. Exceptions still use the base. mtvec_q[1:0] ≥ 2 is treated as direct.
- Undefined: always direct mode; mtvec[1:0] is ignored.

Test Plan:
- Illegal instr: ex_valid=1, ex_invalid=1, ex_pc=0x104, mtvec=0x200, mstatus=0x8 →
  - T+1 write 0x341←0x104
  - T+2 0x342←2
  - T+3 0x300←0x1880
  - T+4 redirect 0x200
  - flush/stall high T+1..T+4
- ecall with irq_timer=1, MIE=1, MTIE=1 simultaneously → cause 11 (exception wins); the timer trap is taken on the first valid IDLE evaluation after return with cause 0x80000007.
- External irq: irq_ext raised, MIE=1, MEIE=1, ex_pc=0x40 → detected after synchronizer delay (2 cycles); mcause=0x8000000B, mepc=0x40. With MIE=0 there is no trap.
- mret: mstatus=0x1880, mepc=0x104 → T+1 write 0x300←0x1888, T+2 redirect 0x104, IDLE at T+3.
- Reset mid-sequence: rst_n low during T_MCAUSE → all outputs 0 at once. After release the block is in IDLE and no further CSR writes occur.
- TRAP_VECTORED_EN: mtvec=0x201, timer irq → redirect 0x21C; illegal instr with the same mtvec → redirect 0x200.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: multi-cycle trap/mret sequencer for the RV32I core.
//   On an exception or an enabled interrupt it flushes the pipeline, writes
//   mepc, mcause and mstatus over a dedicated CSR port, then redirects fetch
//   to mtvec. On mret it restores mstatus and redirects fetch to mepc.
//   Optional macro TRAP_VECTORED_EN enables vectored interrupt targets
//   (mtvec[1:0]==2'b01).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ex_valid, ex_pc                   EX stage instruction valid and PC
//   ex_invalid, ex_ecall, ex_mret     decoder flags for the EX instruction
//   irq_ext                           asynchronous external interrupt level
//   irq_timer                         synchronous timer interrupt level
//   mstatus, mie, mtvec, mepc         current CSR file state
//   csr_trap_we/addr/wdata            dedicated CSR write port
//   flush, stall                      pipeline control
//   redirect_valid, redirect_pc       fetch redirect
//   busy                              sequencer not idle
module trap_ctrl #(
   parameter int XLEN            = 32,
   parameter int IRQ_SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_invalid,
   input  logic            ex_ecall,
   input  logic            ex_mret,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic [XLEN-1:0] mstatus,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            csr_trap_we,
   output logic [11:0]     csr_trap_addr,
   output logic [XLEN-1:0] csr_trap_wdata,
   output logic            flush,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, REDIRECT} state_t;

   localparam logic [XLEN-1:0] INT_BIT = {1'b1, {(XLEN-1){1'b0}}};

   state_t                     state, state_nx;
   logic [IRQ_SYNC_STAGES-1:0] sync;
   logic [XLEN-1:0]            pc_q, cause_q, mstatus_q, mtvec_q, mepc_q;
   logic                       mret_q;
   logic                       irq_s, irq_e, irq_t, trap_any, take_trap, take_mret;
   logic [XLEN-1:0]            cause, ms_trap, ms_mret, tvec_base, trap_pc;
   logic                       unused_bits;

   assign irq_s     = sync[IRQ_SYNC_STAGES-1];
   assign irq_e     = mstatus[3] & mie[11] & irq_s;
   assign irq_t     = mstatus[3] & mie[7] & irq_timer;
   assign trap_any  = ex_invalid | ex_ecall | irq_e | irq_t;
   assign take_trap = (state == IDLE) & ex_valid & trap_any;
   assign take_mret = (state == IDLE) & ex_valid & ex_mret & ~trap_any;
   assign cause     = ex_invalid ? XLEN'(2) :
                      ex_ecall   ? XLEN'(11) :
                      irq_e      ? (INT_BIT | XLEN'(11)) : (INT_BIT | XLEN'(7));
   assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   // Vectored only for interrupts; mode values 2 and 3 fall back to direct.
   assign trap_pc = (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ?
                    tvec_base + {cause_q[XLEN-3:0], 2'b00} : tvec_base;
`else
   assign trap_pc = tvec_base;
`endif

   assign unused_bits = ^{mie[XLEN-1:12], mie[10:8], mie[6:0], mtvec_q[1:0], pc_q[1:0], mepc_q[1:0]};

   always_comb begin
      ms_trap        = mstatus_q;
      ms_trap[12:11] = 2'b11;
      ms_trap[7]     = mstatus_q[3];
      ms_trap[3]     = 1'b0;
      ms_mret        = mstatus_q;
      ms_mret[12:11] = 2'b11;
      ms_mret[7]     = 1'b1;
      ms_mret[3]     = mstatus_q[7];
   end

   always_comb begin
      state_nx = take_trap ? T_MEPC : take_mret ? R_MSTATUS : IDLE;
      case (state)
         T_MEPC:    state_nx = T_MCAUSE;
         T_MCAUSE:  state_nx = T_MSTATUS;
         T_MSTATUS: state_nx = REDIRECT;
         R_MSTATUS: state_nx = REDIRECT;
         REDIRECT:  state_nx = IDLE;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sync      <= '0;
         pc_q      <= '0;
         cause_q   <= '0;
         mstatus_q <= '0;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mret_q    <= 1'b0;
      end else begin
         state <= state_nx;
         sync  <= {sync[IRQ_SYNC_STAGES-2:0], irq_ext};
         if (take_trap || take_mret) begin
            pc_q      <= ex_pc;
            cause_q   <= cause;
            mstatus_q <= mstatus;
            mtvec_q   <= mtvec;
            mepc_q    <= mepc;
            mret_q    <= take_mret;
         end
      end
   end

   always_comb begin
      busy           = state != IDLE;
      flush          = busy;
      stall          = busy;
      redirect_valid = state == REDIRECT;
      redirect_pc    = redirect_valid ? (mret_q ? {mepc_q[XLEN-1:2], 2'b00} : trap_pc) : '0;
      csr_trap_we    = state inside {T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS};
      csr_trap_addr  = state == T_MEPC   ? 12'h341 :
                       state == T_MCAUSE ? 12'h342 :
                       csr_trap_we       ? 12'h300 : 12'h000;
      csr_trap_wdata = state == T_MEPC    ? {pc_q[XLEN-1:2], 2'b00} :
                       state == T_MCAUSE  ? cause_q :
                       state == T_MSTATUS ? ms_trap :
                       state == R_MSTATUS ? ms_mret : '0;
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_invalid = 1'b0, ex_ecall = 1'b0, ex_mret = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        irq_ext = 1'b0, irq_timer = 1'b0;
   logic [31:0] mstatus = '0, mie = '0, mtvec = '0, mepc = '0;
   logic        csr_trap_we, flush, stall, redirect_valid, busy;
   logic [11:0] csr_trap_addr;
   logic [31:0] csr_trap_wdata, redirect_pc;
   int          n_cmp = 0, n_err = 0;

   // {we, addr, wdata, flush, stall, redirect_valid, redirect_pc, busy}
   wire [80:0] obs = {csr_trap_we, csr_trap_addr, csr_trap_wdata, flush, stall,
                      redirect_valid, redirect_pc, busy};

   localparam logic [80:0] IDLE_O = '0;

   always #5 clk = ~clk;

   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_invalid(ex_invalid), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
      .irq_ext(irq_ext), .irq_timer(irq_timer), .mstatus(mstatus), .mie(mie),
      .mtvec(mtvec), .mepc(mepc), .csr_trap_we(csr_trap_we),
      .csr_trap_addr(csr_trap_addr), .csr_trap_wdata(csr_trap_wdata),
      .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [80:0] wr(input logic [11:0] a, input logic [31:0] d);
      return {1'b1, a, d, 3'b110, 32'h0, 1'b1};
   endfunction

   function automatic logic [80:0] rd(input logic [31:0] pc);
      return {1'b0, 12'h0, 32'h0, 3'b111, pc, 1'b1};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL reset obs=%h exp=%h", obs, IDLE_O); n_err++; end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL reset_release obs=%h exp=%h", obs, IDLE_O); n_err++; end
   endtask

   task automatic test_illegal();
      logic [80:0] e [4] = '{wr(12'h341, 32'h104), wr(12'h342, 32'h2),
                             wr(12'h300, 32'h1880), rd(32'h200)};
      mstatus = 32'h8; mie = '0; mtvec = 32'h200; ex_pc = 32'h104;
      ex_valid = 1'b1; ex_invalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         ex_valid = 1'b0; ex_invalid = 1'b0;
         n_cmp++;
         if (obs !== e[i]) begin $display("FAIL illegal_step%0d obs=%h exp=%h", i, obs, e[i]); n_err++; end
      end
      tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL illegal_idle obs=%h exp=%h", obs, IDLE_O); n_err++; end
   endtask

   task automatic test_ecall_timer();
      mstatus = 32'h8; mie = 32'h80; mtvec = 32'h200; ex_pc = 32'h300;
      irq_timer = 1'b1; ex_valid = 1'b1; ex_ecall = 1'b1;
      tick();
      ex_valid = 1'b0; ex_ecall = 1'b0;
      tick();
      n_cmp++;
      if (obs !== wr(12'h342, 32'd11)) begin $display("FAIL ecall_cause obs=%h exp=%h", obs, wr(12'h342, 32'd11)); n_err++; end
      tick(); tick(); tick();
      tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL bubble_wait obs=%h exp=%h", obs, IDLE_O); n_err++; end
      ex_pc = 32'h304; ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0;
      n_cmp++;
      if (obs !== wr(12'h341, 32'h304)) begin $display("FAIL timer_mepc obs=%h exp=%h", obs, wr(12'h341, 32'h304)); n_err++; end
      tick();
      n_cmp++;
      if (obs !== wr(12'h342, 32'h80000007)) begin $display("FAIL timer_cause obs=%h exp=%h", obs, wr(12'h342, 32'h80000007)); n_err++; end
      irq_timer = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_ext_irq();
      mstatus = 32'h8; mie = 32'h800; mtvec = 32'h200; ex_pc = 32'h40;
      ex_valid = 1'b1; irq_ext = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b0) begin $display("FAIL ext_sync_delay%0d busy=%b exp=0", i, busy); n_err++; end
      end
      tick();
      ex_valid = 1'b0;
      n_cmp++;
      if (obs !== wr(12'h341, 32'h40)) begin $display("FAIL ext_mepc obs=%h exp=%h", obs, wr(12'h341, 32'h40)); n_err++; end
      tick();
      n_cmp++;
      if (obs !== wr(12'h342, 32'h8000000B)) begin $display("FAIL ext_cause obs=%h exp=%h", obs, wr(12'h342, 32'h8000000B)); n_err++; end
      tick(); tick(); tick();
      mstatus = 32'h0; ex_valid = 1'b1;
      tick(); tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL ext_masked obs=%h exp=%h", obs, IDLE_O); n_err++; end
      ex_valid = 1'b0; irq_ext = 1'b0;
   endtask

   task automatic test_mret();
      mstatus = 32'h1880; mepc = 32'h104; mtvec = 32'h200; mie = '0;
      ex_valid = 1'b1; ex_mret = 1'b1;
      tick();
      ex_valid = 1'b0; ex_mret = 1'b0; mstatus = 32'h0;
      n_cmp++;
      if (obs !== wr(12'h300, 32'h1888)) begin $display("FAIL mret_mstatus obs=%h exp=%h", obs, wr(12'h300, 32'h1888)); n_err++; end
      tick();
      n_cmp++;
      if (obs !== rd(32'h104)) begin $display("FAIL mret_redirect obs=%h exp=%h", obs, rd(32'h104)); n_err++; end
      tick();
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL mret_idle obs=%h exp=%h", obs, IDLE_O); n_err++; end
   endtask

   task automatic test_reset_mid();
      mstatus = 32'h8; mtvec = 32'h200; ex_pc = 32'h104;
      ex_valid = 1'b1; ex_invalid = 1'b1;
      tick();
      ex_valid = 1'b0; ex_invalid = 1'b0;
      tick();
      n_cmp++;
      if (obs !== wr(12'h342, 32'h2)) begin $display("FAIL mid_pre obs=%h exp=%h", obs, wr(12'h342, 32'h2)); n_err++; end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== IDLE_O) begin $display("FAIL mid_async obs=%h exp=%h", obs, IDLE_O); n_err++; end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (obs !== IDLE_O) begin $display("FAIL mid_after%0d obs=%h exp=%h", i, obs, IDLE_O); n_err++; end
      end
   endtask

   task automatic test_vectored();
`ifdef TRAP_VECTORED_EN
      logic [31:0] exp_irq = 32'h21C;
`else
      logic [31:0] exp_irq = 32'h200;
`endif
      mstatus = 32'h8; mie = 32'h80; mtvec = 32'h201; ex_pc = 32'h500;
      ex_valid = 1'b1; irq_timer = 1'b1;
      tick();
      ex_valid = 1'b0; irq_timer = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (obs !== rd(exp_irq)) begin $display("FAIL vec_irq obs=%h exp=%h", obs, rd(exp_irq)); n_err++; end
      tick();
      ex_valid = 1'b1; ex_invalid = 1'b1;
      tick();
      ex_valid = 1'b0; ex_invalid = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (obs !== rd(32'h200)) begin $display("FAIL vec_exc obs=%h exp=%h", obs, rd(32'h200)); n_err++; end
      tick();
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_ecall_timer();
      test_ext_irq();
      test_mret();
      test_reset_mid();
      test_vectored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
